// File: rtl/inst_queue.sv
// Dual-issue instruction buffer between IF and ID: holds fetched pairs, runs them through the
// second-level branch lookup, handles the MIPS delay slot and issues a one-shot redirect to IF.
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid1,
  input  logic        if_valid2,
  input  logic [31:0] if_inst_addr1,
  input  logic [31:0] if_inst_addr2,
  input  logic [31:0] if_inst1,
  input  logic [31:0] if_inst2,
  output logic        buffer_full,
  output logic        bpu_lookup_valid1,
  output logic        bpu_lookup_valid2,
  output logic [31:0] bpu_inst_addr1,
  output logic [31:0] bpu_inst_addr2,
  output logic [31:0] bpu_inst1,
  output logic [31:0] bpu_inst2,
  input  logic        bpu_predict_happen1,
  input  logic        bpu_predict_happen2,
  input  logic [31:0] bpu_predict_addr1,
  input  logic [31:0] bpu_predict_addr2,
  output logic        id_valid1,
  output logic        id_valid2,
  output logic [31:0] id_inst_addr1,
  output logic [31:0] id_inst_addr2,
  output logic [31:0] id_inst1,
  output logic [31:0] id_inst2,
  output logic        id_predict_happen1,
  output logic        id_predict_happen2,
  output logic [31:0] id_predict_addr1,
  output logic [31:0] id_predict_addr2,
  input  logic [1:0]  id_pop_num,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_DS = 2'd1;
  localparam logic [1:0] S_REDIR   = 2'd2;

  localparam logic [AW:0] PTR_ZERO   = '0;
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [AW:0] PTR_TWO    = (AW+1)'(2);
  localparam logic [AW:0] FULL_LIMIT = (AW+1)'(DEPTH-2);

  logic [31:0]      addr_mem  [DEPTH];
  logic [31:0]      inst_mem  [DEPTH];
  logic [31:0]      paddr_mem [DEPTH];
  logic [DEPTH-1:0] happen_mem;

  logic [AW:0]  rd_q, rd_d, chk_q, chk_d, wr_q, wr_d;
  logic [1:0]   state_q, state_d;
  logic         redir_valid_q, redir_valid_d;
  logic [31:0]  redir_addr_q, redir_addr_d;
  logic [31:0]  target_q, target_d;

  logic [AW:0]   lk_cnt, id_cnt, used_cnt, lk_n, id_n, pop_n, push_n;
  logic          lk_v1, lk_v2, id_v1, id_v2, full, accept_push;
  logic [AW-1:0] chk_i0, chk_i1, rd_i0, rd_i1, wr_i0, wr_i1;

  logic          push_en1, push_en2;
  logic          rec_en1, rec_en2, rec_h1, rec_h2;
  logic [31:0]   rec_pa1, rec_pa2;

  // Pointer windows: [rd,chk) is dispatchable, [chk,wr) still waits for its lookup.
  assign lk_cnt   = wr_q - chk_q;
  assign id_cnt   = chk_q - rd_q;
  assign used_cnt = wr_q - rd_q;

  assign lk_v1 = (lk_cnt != PTR_ZERO);
  assign lk_v2 = (lk_cnt >= PTR_TWO);
  assign id_v1 = (id_cnt != PTR_ZERO);
  assign id_v2 = (id_cnt >= PTR_TWO);
  assign full  = (used_cnt > FULL_LIMIT);

  assign lk_n = lk_v2 ? PTR_TWO : (lk_v1 ? PTR_ONE : PTR_ZERO);
  assign id_n = id_v2 ? PTR_TWO : (id_v1 ? PTR_ONE : PTR_ZERO);

  assign chk_i0 = chk_q[AW-1:0];
  assign chk_i1 = chk_i0 + AW'(1);
  assign rd_i0  = rd_q[AW-1:0];
  assign rd_i1  = rd_i0 + AW'(1);
  assign wr_i0  = wr_q[AW-1:0];
  assign wr_i1  = wr_i0 + AW'(1);

  assign accept_push = if_valid1 && !full;

  always_comb begin
    pop_n = PTR_ZERO;
    case (id_pop_num)
      2'd0:    pop_n = PTR_ZERO;
      2'd1:    pop_n = id_v1 ? PTR_ONE : PTR_ZERO;
      default: pop_n = id_n;
    endcase
  end

  always_comb begin
    rd_d          = rd_q + pop_n;
    chk_d         = chk_q;
    wr_d          = wr_q;
    state_d       = state_q;
    redir_valid_d = 1'b0;
    redir_addr_d  = redir_addr_q;
    target_d      = target_q;
    push_en1      = 1'b0;
    push_en2      = 1'b0;
    push_n        = PTR_ZERO;
    rec_en1       = 1'b0;
    rec_en2       = 1'b0;
    rec_h1        = 1'b0;
    rec_h2        = 1'b0;
    rec_pa1       = '0;
    rec_pa2       = '0;

    case (state_q)
      S_IDLE: begin
        if (lk_v1 && bpu_predict_happen1) begin
          rec_en1  = 1'b1;
          rec_h1   = 1'b1;
          rec_pa1  = bpu_predict_addr1;
          target_d = bpu_predict_addr1;
          if (lk_v2) begin
            // Slot2 is the delay slot; everything fetched after it is wrong-path.
            rec_en2       = 1'b1;
            chk_d         = chk_q + PTR_TWO;
            wr_d          = chk_q + PTR_TWO;
            state_d       = S_REDIR;
            redir_valid_d = 1'b1;
            redir_addr_d  = bpu_predict_addr1;
          end else begin
            chk_d   = chk_q + PTR_ONE;
            state_d = S_WAIT_DS;
          end
        end else if (lk_v2 && bpu_predict_happen2) begin
          rec_en1  = 1'b1;
          rec_pa1  = bpu_predict_addr1;
          rec_en2  = 1'b1;
          rec_h2   = 1'b1;
          rec_pa2  = bpu_predict_addr2;
          target_d = bpu_predict_addr2;
          chk_d    = chk_q + PTR_TWO;
          state_d  = S_WAIT_DS;
        end else begin
          rec_en1  = lk_v1;
          rec_h1   = bpu_predict_happen1;
          rec_pa1  = bpu_predict_addr1;
          rec_en2  = lk_v2;
          rec_h2   = bpu_predict_happen2;
          rec_pa2  = bpu_predict_addr2;
          chk_d    = chk_q + lk_n;
          push_en1 = accept_push;
          push_en2 = accept_push && if_valid2;
          push_n   = push_en2 ? PTR_TWO : (push_en1 ? PTR_ONE : PTR_ZERO);
          wr_d     = wr_q + push_n;
        end
      end

      S_WAIT_DS: begin
        if (chk_q != wr_q) begin
          rec_en1       = 1'b1;
          chk_d         = chk_q + PTR_ONE;
          wr_d          = chk_q + PTR_ONE;
          state_d       = S_REDIR;
          redir_valid_d = 1'b1;
          redir_addr_d  = target_q;
        end else if (accept_push) begin
          push_en1      = 1'b1;
          chk_d         = wr_q + PTR_ONE;
          wr_d          = wr_q + PTR_ONE;
          state_d       = S_REDIR;
          redir_valid_d = 1'b1;
          redir_addr_d  = target_q;
        end
      end

      S_REDIR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      rd_d          = PTR_ZERO;
      chk_d         = PTR_ZERO;
      wr_d          = PTR_ZERO;
      state_d       = S_IDLE;
      redir_valid_d = 1'b0;
      redir_addr_d  = '0;
      target_d      = '0;
      push_en1      = 1'b0;
      push_en2      = 1'b0;
      rec_en1       = 1'b0;
      rec_en2       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q          <= PTR_ZERO;
      chk_q         <= PTR_ZERO;
      wr_q          <= PTR_ZERO;
      state_q       <= S_IDLE;
      redir_valid_q <= 1'b0;
      redir_addr_q  <= '0;
      target_q      <= '0;
    end else begin
      rd_q          <= rd_d;
      chk_q         <= chk_d;
      wr_q          <= wr_d;
      state_q       <= state_d;
      redir_valid_q <= redir_valid_d;
      redir_addr_q  <= redir_addr_d;
      target_q      <= target_d;
    end
  end

  // Storage needs no reset: every read port is gated by its pointer window.
  always_ff @(posedge clk) begin
    if (push_en1) begin
      addr_mem[wr_i0]   <= if_inst_addr1;
      inst_mem[wr_i0]   <= if_inst1;
      happen_mem[wr_i0] <= 1'b0;
      paddr_mem[wr_i0]  <= '0;
    end
    if (push_en2) begin
      addr_mem[wr_i1]   <= if_inst_addr2;
      inst_mem[wr_i1]   <= if_inst2;
      happen_mem[wr_i1] <= 1'b0;
      paddr_mem[wr_i1]  <= '0;
    end
    if (rec_en1) begin
      happen_mem[chk_i0] <= rec_h1;
      paddr_mem[chk_i0]  <= rec_pa1;
    end
    if (rec_en2) begin
      happen_mem[chk_i1] <= rec_h2;
      paddr_mem[chk_i1]  <= rec_pa2;
    end
  end

  assign buffer_full = full;

  assign bpu_lookup_valid1 = lk_v1;
  assign bpu_lookup_valid2 = lk_v2;
  assign bpu_inst_addr1    = lk_v1 ? addr_mem[chk_i0] : '0;
  assign bpu_inst_addr2    = lk_v2 ? addr_mem[chk_i1] : '0;
  assign bpu_inst1         = lk_v1 ? inst_mem[chk_i0] : '0;
  assign bpu_inst2         = lk_v2 ? inst_mem[chk_i1] : '0;

  assign id_valid1          = id_v1;
  assign id_valid2          = id_v2;
  assign id_inst_addr1      = id_v1 ? addr_mem[rd_i0] : '0;
  assign id_inst_addr2      = id_v2 ? addr_mem[rd_i1] : '0;
  assign id_inst1           = id_v1 ? inst_mem[rd_i0] : '0;
  assign id_inst2           = id_v2 ? inst_mem[rd_i1] : '0;
  assign id_predict_happen1 = id_v1 && happen_mem[rd_i0];
  assign id_predict_happen2 = id_v2 && happen_mem[rd_i1];
  assign id_predict_addr1   = id_v1 ? paddr_mem[rd_i0] : '0;
  assign id_predict_addr2   = id_v2 ? paddr_mem[rd_i1] : '0;

  assign redirect_valid = redir_valid_q;
  assign redirect_addr  = redir_addr_q;

endmodule
